pipe_chain: RTL and testbench

- Parametrised elastic pipeline register chain: DEPTH stages of WIDTH-bit payload with valid/ready handshake, bubble collapsing and global flush.
- Generalises the fixed, stall-less inter-stage registers (if_id, id_ex, ex_mem, mem_wb) of the 5-stage core.
- Instantiated between pipeline stages so the core can stall and flush, e.g. on load-use hazards and branches.

---
 rtl/pipe_chain.sv | 115 +++++++++++
 tb/tb_pipe_chain.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_chain.sv
// Elastic valid/ready register chain with bubble collapsing, global flush and occupancy count.
// Define PIPE_CHAIN_SKID_EN to add a skid entry ahead of stage 0 so that in_ready comes from a flop.
module pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1,
  parameter int CNT_W = $clog2(DEPTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0] v_reg;
  logic [DEPTH-1:0] v_next;
  logic [WIDTH-1:0] d_reg [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] adv;
  logic [CNT_W-1:0] occ_reg;
  logic             push;
  logic             pop;
  logic             s0_free;
  logic             s0_load;
  logic [WIDTH-1:0] s0_data;

  // A stage advances when the stage ahead is empty or is itself advancing.
  assign adv[DEPTH-1] = v_reg[DEPTH-1] & out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH - 1; gi++) begin : g_adv
      assign adv[gi] = v_reg[gi] & (~v_reg[gi+1] | adv[gi+1]);
    end

    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign load[gi]  = s0_load;
        assign src_d[gi] = s0_data;
      end else begin : g_rest
        assign load[gi]  = adv[gi-1];
        assign src_d[gi] = d_reg[gi-1];
      end
      assign v_next[gi] = load[gi] | (v_reg[gi] & ~adv[gi]);
    end
  endgenerate

  assign s0_free = ~v_reg[0] | adv[0];
  assign pop     = adv[DEPTH-1];

`ifdef PIPE_CHAIN_SKID_EN
  logic             sv_reg;
  logic [WIDTH-1:0] sd_reg;

  assign in_ready = ~rst & ~flush & ~sv_reg;
  assign push     = in_valid & in_ready;
  // A held skid entry always goes first so ordering is preserved.
  assign s0_load  = (sv_reg | push) & s0_free;
  assign s0_data  = sv_reg ? sd_reg : in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      sv_reg <= 1'b0;
      sd_reg <= '0;
    end else if (flush) begin
      sv_reg <= 1'b0;
    end else if (push & ~s0_free) begin
      sv_reg <= 1'b1;
      sd_reg <= in_data;
    end else if (sv_reg & s0_free) begin
      sv_reg <= 1'b0;
    end
  end
`else
  assign in_ready = ~rst & ~flush & s0_free;
  assign push     = in_valid & in_ready;
  assign s0_load  = push;
  assign s0_data  = in_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      v_reg <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_reg[k] <= '0;
      end
    end else begin
      v_reg <= flush ? '0 : v_next;
      for (int k = 0; k < DEPTH; k++) begin
        if (load[k]) begin
          d_reg[k] <= src_d[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign out_valid = v_reg[DEPTH-1];
  assign out_data  = d_reg[DEPTH-1];
  assign occupancy = occ_reg;

endmodule

// File: tb/tb_pipe_chain.sv
// Directed self-checking bench for pipe_chain: three instances (DEPTH 3, 4 and 2).
// The DEPTH=2 instance checks the skid-buffer capacity when PIPE_CHAIN_SKID_EN is defined.
module tb_pipe_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // DEPTH = 3 instance
  logic        a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [31:0] a_in_data, a_out_data;
  logic [2:0]  a_occupancy;
  // DEPTH = 4 instance
  logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [31:0] b_in_data, b_out_data;
  logic [2:0]  b_occupancy;
  // DEPTH = 2 instance
  logic        c_rst, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush;
  logic [31:0] c_in_data, c_out_data;
  logic [1:0]  c_occupancy;

  pipe_chain #(.WIDTH(32), .DEPTH(3)) u_a (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .flush(a_flush), .occupancy(a_occupancy)
  );

  pipe_chain #(.WIDTH(32), .DEPTH(4)) u_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .flush(b_flush), .occupancy(b_occupancy)
  );

  pipe_chain #(.WIDTH(32), .DEPTH(2)) u_c (
    .clk(clk), .rst(c_rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .flush(c_flush), .occupancy(c_occupancy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Land 1 time unit after the rising edge; inputs are driven and registered outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input logic [31:0] data, input string tag);
    a_in_valid = 1'b1;
    a_in_data  = data;
    #1;
    check(tag, a_in_ready, 1);
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic c_push(input logic [31:0] data, input string tag);
    c_in_valid = 1'b1;
    c_in_data  = data;
    #1;
    check(tag, c_in_ready, 1);
    tick();
    c_in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    a_rst = 1; a_in_valid = 1; a_in_data = 32'hDEAD; a_out_ready = 0; a_flush = 0;
    b_rst = 1; b_in_valid = 0; b_in_data = 0; b_out_ready = 0; b_flush = 0;
    c_rst = 1; c_in_valid = 0; c_in_data = 0; c_out_ready = 0; c_flush = 0;
    tick();
    tick();
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_occ", a_occupancy, 0);
    a_rst = 0; b_rst = 0; c_rst = 0; a_in_valid = 0;

    // Unstalled stream: DEPTH cycles of latency, then one per cycle
    a_out_ready = 1;
    a_push(32'h11, "t1_rdy0");
    a_push(32'h22, "t1_rdy1");
    a_push(32'h33, "t1_rdy2");
    check("t1_head0", a_out_data, 32'h11);
    check("t1_valid0", a_out_valid, 1);
    check("t1_occ_peak", a_occupancy, 3);
    tick();
    check("t1_head1", a_out_data, 32'h22);
    check("t1_occ2", a_occupancy, 2);
    tick();
    check("t1_head2", a_out_data, 32'h33);
    tick();
    check("t1_empty", a_out_valid, 0);
    check("t1_occ0", a_occupancy, 0);

`ifndef PIPE_CHAIN_SKID_EN
    // Backpressure, then simultaneous pop and push on a full chain
    a_out_ready = 0;
    a_push(32'h11, "t2_rdy0");
    a_push(32'h22, "t2_rdy1");
    a_push(32'h33, "t2_rdy2");
    a_in_valid = 1; a_in_data = 32'h44;
    #1;
    check("t2_full_rdy", a_in_ready, 0);
    check("t2_full_occ", a_occupancy, 3);
    tick();
    check("t2_hold_occ", a_occupancy, 3);
    check("t2_hold_head", a_out_data, 32'h11);
    a_out_ready = 1;
    #1;
    check("t2_pushpop_rdy", a_in_ready, 1);
    tick();
    a_in_valid = 0;
    check("t2_pushpop_occ", a_occupancy, 3);
    check("t2_head22", a_out_data, 32'h22);
    tick();
    check("t2_head33", a_out_data, 32'h33);
    tick();
    check("t2_head44", a_out_data, 32'h44);
    tick();
    check("t2_drain_occ", a_occupancy, 0);
`endif

    // Flush with a full chain and a pending input
    a_out_ready = 0;
    a_push(32'hA1, "t4_rdy0");
    a_push(32'hA2, "t4_rdy1");
    a_push(32'hA3, "t4_rdy2");
    check("t4_occ3", a_occupancy, 3);
    a_flush = 1; a_in_valid = 1; a_in_data = 32'hEE;
    #1;
    check("t4_flush_rdy", a_in_ready, 0);
    tick();
    a_flush = 0; a_in_valid = 0;
    check("t4_occ0", a_occupancy, 0);
    check("t4_valid0", a_out_valid, 0);
    a_out_ready = 1;
    tick(); tick(); tick();
    check("t4_nocapture", a_out_valid, 0);
    check("t4_nocapture_occ", a_occupancy, 0);

    // Reset mid-stream, then a fresh push sees full latency
    a_out_ready = 0;
    a_push(32'h55, "t5_rdy0");
    a_push(32'h66, "t5_rdy1");
    tick();
    check("t5_occ2", a_occupancy, 2);
    check("t5_head55", a_out_data, 32'h55);
    a_rst = 1; a_in_valid = 1; a_in_data = 32'h99;
    #1;
    check("t5_rst_rdy", a_in_ready, 0);
    tick();
    a_rst = 0; a_in_valid = 0;
    check("t5_valid0", a_out_valid, 0);
    check("t5_data0", a_out_data, 0);
    check("t5_occ0", a_occupancy, 0);
    a_out_ready = 1;
    a_push(32'h77, "t5_rdy_post");
    check("t5_lat1", a_out_valid, 0);
    tick();
    check("t5_lat2", a_out_valid, 0);
    tick();
    check("t5_lat3_valid", a_out_valid, 1);
    check("t5_lat3_data", a_out_data, 32'h77);

    // DEPTH=4 bubble collapse behind a stalled head
    b_out_ready = 1;
    b_in_valid = 1; b_in_data = 32'hA;
    tick();                         // t1
    b_in_valid = 0;
    tick();                         // t2
    b_in_valid = 1; b_in_data = 32'hB;
    tick();                         // t3
    b_in_valid = 0;
    check("t3_lat_t3", b_out_valid, 0);
    tick();                         // t4
    b_out_ready = 0;
    check("t3_head_a_t4", b_out_data, 32'hA);
    check("t3_valid_t4", b_out_valid, 1);
    tick();                         // t5
    check("t3_occ_t5", b_occupancy, 2);
    check("t3_head_a_t5", b_out_data, 32'hA);
    tick();                         // t6
    b_out_ready = 1;
    check("t3_head_a_t6", b_out_data, 32'hA);
    tick();                         // t7
    check("t3_head_b_t7", b_out_data, 32'hB);
    check("t3_valid_t7", b_out_valid, 1);
    check("t3_occ_t7", b_occupancy, 1);
    tick();
    check("t3_empty", b_out_valid, 0);
    check("t3_occ0", b_occupancy, 0);

    // DEPTH=2 capacity under backpressure
    c_out_ready = 0;
    c_push(32'h1, "t6_rdy0");
    c_push(32'h2, "t6_rdy1");
    c_in_valid = 1; c_in_data = 32'h3;
    #1;
`ifdef PIPE_CHAIN_SKID_EN
    check("t6_rdy2", c_in_ready, 1);
    tick();
    c_in_valid = 0;
    check("t6_full_rdy", c_in_ready, 0);
    check("t6_occ3", c_occupancy, 3);
`else
    check("t6_rdy2", c_in_ready, 0);
    tick();
    c_in_valid = 0;
    check("t6_occ2", c_occupancy, 2);
`endif
    c_out_ready = 1;
    check("t6_head1", c_out_data, 32'h1);
    tick();
    check("t6_head2", c_out_data, 32'h2);
    tick();
`ifdef PIPE_CHAIN_SKID_EN
    check("t6_head3", c_out_data, 32'h3);
    tick();
`endif
    check("t6_empty", c_out_valid, 0);
    check("t6_occ0", c_occupancy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
